// File: rtl/call_latch_pkg.sv
// Shared constants for the elevator call latch: default floor count,
// elevator_status bit positions and the floor / pending count width.
package call_latch_pkg;

    localparam int N_FLOOR_DEF = 8;
    localparam int FLOOR_W     = 4;

    localparam int ST_UP    = 3;
    localparam int ST_DOWN  = 2;
    localparam int ST_OPEN  = 1;
    localparam int ST_CLOSE = 0;

endpackage

// File: rtl/call_latch_sync_edge.sv
// Multi-stage synchroniser followed by a "previous" flop; rise is a
// one-cycle pulse on each 0->1 transition of the synchronised level.
module sync_edge #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [W-1:0] sync_q [STAGES];
    logic [W-1:0] sync_d [STAGES];
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    always_comb begin
        sync_d[0] = din;
        for (int s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_q <= prev_d;
        end
    end

    // A level held through reset release shows up as a single rising edge.
    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/call_latch.sv
// Hall-call and car-button request latches with registered above/below/here
// summaries. Define CALL_CANCEL_EN to let a re-press cancel a car request.
module call_latch
    import call_latch_pkg::*;
#(
    parameter int N_FLOOR     = N_FLOOR_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_FLOOR-1:0] up_btn,
    input  logic [N_FLOOR-1:0] down_btn,
    input  logic [N_FLOOR-1:0] car_btn,
    input  logic [FLOOR_W-1:0] floor,
    input  logic [3:0]         elevator_status,
    output logic [N_FLOOR-1:0] up_call,
    output logic [N_FLOOR-1:0] down_call,
    output logic [N_FLOOR-1:0] floor_btn,
    output logic               req_above,
    output logic               req_below,
    output logic               req_here,
    output logic [FLOOR_W-1:0] pending_cnt
);

    localparam logic [FLOOR_W-1:0] N_FLOOR_L = FLOOR_W'(N_FLOOR);

    logic [N_FLOOR-1:0] up_rise, down_rise, car_rise;

    sync_edge #(.W(N_FLOOR), .STAGES(SYNC_STAGES)) u_sync_up (
        .clk(CLK), .rst_n(RST), .din(up_btn), .rise(up_rise)
    );
    sync_edge #(.W(N_FLOOR), .STAGES(SYNC_STAGES)) u_sync_down (
        .clk(CLK), .rst_n(RST), .din(down_btn), .rise(down_rise)
    );
    sync_edge #(.W(N_FLOOR), .STAGES(SYNC_STAGES)) u_sync_car (
        .clk(CLK), .rst_n(RST), .din(car_btn), .rise(car_rise)
    );

    logic [N_FLOOR-1:0] up_q, up_d;
    logic [N_FLOOR-1:0] down_q, down_d;
    logic [N_FLOOR-1:0] car_q, car_d;
    logic               above_q, above_d;
    logic               below_q, below_d;
    logic               here_q, here_d;
    logic [FLOOR_W-1:0] cnt_q, cnt_d;

    logic               floor_ok;
    logic               open_ok;
    logic               st_up, st_dn;
    logic [N_FLOOR-1:0] at_floor;
    logic [N_FLOOR-1:0] clr_up, clr_dn, clr_car;
    logic [N_FLOOR-1:0] car_next;
    logic [N_FLOOR-1:0] any_req;

    always_comb begin
        floor_ok = (floor < N_FLOOR_L);
        open_ok  = elevator_status[ST_OPEN] & floor_ok;
        st_up    = elevator_status[ST_UP];
        st_dn    = elevator_status[ST_DOWN];
        for (int i = 0; i < N_FLOOR; i++) begin
            at_floor[i] = (FLOOR_W'(i) == floor);
        end
        // Idle and the illegal up+down encoding both clear both hall bits.
        clr_car = open_ok ? at_floor : '0;
        clr_up  = (open_ok && (st_up || !st_dn)) ? at_floor : '0;
        clr_dn  = (open_ok && (st_dn || !st_up)) ? at_floor : '0;

`ifdef CALL_CANCEL_EN
        car_next = car_q ^ car_rise;
`else
        car_next = car_q | car_rise;
`endif

        car_d  = car_next & ~clr_car;
        up_d   = (up_q | up_rise) & ~clr_up;
        down_d = (down_q | down_rise) & ~clr_dn;
        up_d[N_FLOOR-1] = 1'b0;
        down_d[0]       = 1'b0;
    end

    always_comb begin
        any_req = up_q | down_q | car_q;
        above_d = 1'b0;
        below_d = 1'b0;
        here_d  = 1'b0;
        cnt_d   = '0;
        for (int i = 0; i < N_FLOOR; i++) begin
            cnt_d = cnt_d + FLOOR_W'(any_req[i]);
            if (FLOOR_W'(i) > floor) begin
                above_d = above_d | any_req[i];
            end
            if (FLOOR_W'(i) < floor) begin
                below_d = below_d | any_req[i];
            end
            if (FLOOR_W'(i) == floor) begin
                here_d = here_d | any_req[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            up_q    <= '0;
            down_q  <= '0;
            car_q   <= '0;
            above_q <= 1'b0;
            below_q <= 1'b0;
            here_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            up_q    <= up_d;
            down_q  <= down_d;
            car_q   <= car_d;
            above_q <= above_d;
            below_q <= below_d;
            here_q  <= here_d;
            cnt_q   <= cnt_d;
        end
    end

    assign up_call     = up_q;
    assign down_call   = down_q;
    assign floor_btn   = car_q;
    assign req_above   = above_q;
    assign req_below   = below_q;
    assign req_here    = here_q;
    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_call_latch.sv
// Directed bench for call_latch: summary table over floor/status plus
// hand-written press, clear, reset and cancel sequences.
module tb_call_latch;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] up_btn, down_btn, car_btn;
    logic [3:0] floor;
    logic [3:0] elevator_status;
    logic [7:0] up_call, down_call, floor_btn;
    logic       req_above, req_below, req_here;
    logic [3:0] pending_cnt;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    call_latch dut (
        .CLK(CLK), .RST(RST),
        .up_btn(up_btn), .down_btn(down_btn), .car_btn(car_btn),
        .floor(floor), .elevator_status(elevator_status),
        .up_call(up_call), .down_call(down_call), .floor_btn(floor_btn),
        .req_above(req_above), .req_below(req_below), .req_here(req_here),
        .pending_cnt(pending_cnt)
    );

    typedef struct {
        logic [3:0] fl;
        logic [3:0] st;
        logic       above;
        logic       below;
        logic       here;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_up"}, int'(up_call), 0);
        check({name, "_down"}, int'(down_call), 0);
        check({name, "_car"}, int'(floor_btn), 0);
        check({name, "_sum"}, int'({req_above, req_below, req_here}), 0);
        check({name, "_cnt"}, int'(pending_cnt), 0);
    endtask

    initial begin
        // status bits {up, down, open, close}; latched: up_call=0x04, floor_btn=0x20
        vecs[0] = '{4'd0,  4'b0000, 1'b1, 1'b0, 1'b0, 4'd2};
        vecs[1] = '{4'd2,  4'b0000, 1'b1, 1'b0, 1'b1, 4'd2};
        vecs[2] = '{4'd3,  4'b0000, 1'b1, 1'b1, 1'b0, 4'd2};
        vecs[3] = '{4'd5,  4'b0001, 1'b0, 1'b1, 1'b1, 4'd2};
        vecs[4] = '{4'd7,  4'b1000, 1'b0, 1'b1, 1'b0, 4'd2};
        vecs[5] = '{4'd9,  4'b0010, 1'b0, 1'b1, 1'b0, 4'd2};
        vecs[6] = '{4'd12, 4'b1110, 1'b0, 1'b1, 1'b0, 4'd2};
        vecs[7] = '{4'd15, 4'b0110, 1'b0, 1'b1, 1'b0, 4'd2};

        RST = 1'b0;
        up_btn = '0; down_btn = '0; car_btn = '0;
        floor = 4'd0; elevator_status = 4'b0000;
        tick(3);
        check_all_zero("in_reset");
        RST = 1'b1;
        tick(4);
        check_all_zero("after_release");

        // single-cycle up press at floor 2
        up_btn[2] = 1'b1;
        tick(1);
        up_btn[2] = 1'b0;
        tick(1);
        check("up_latency_early", int'(up_call), 'h00);
        tick(1);
        check("up_latched", int'(up_call), 'h04);
        check("cnt_not_yet", int'(pending_cnt), 0);
        tick(1);
        check("cnt_one", int'(pending_cnt), 1);
        check("above_one", int'(req_above), 1);

        // long car press latched once
        car_btn[5] = 1'b1;
        tick(20);
        car_btn[5] = 1'b0;
        tick(3);
        check("car5_latched", int'(floor_btn), 'h20);

        for (int v = 0; v < 8; v++) begin
            floor = vecs[v].fl;
            elevator_status = vecs[v].st;
            tick(1);
            check($sformatf("vec%0d_above", v), int'(req_above), int'(vecs[v].above));
            check($sformatf("vec%0d_below", v), int'(req_below), int'(vecs[v].below));
            check($sformatf("vec%0d_here", v), int'(req_here), int'(vecs[v].here));
            check($sformatf("vec%0d_cnt", v), int'(pending_cnt), int'(vecs[v].cnt));
            check($sformatf("vec%0d_latch", v), int'({up_call, down_call, floor_btn}), 'h040020);
        end

        // serve floor 5 going up
        floor = 4'd5;
        elevator_status = 4'b1010;
        tick(1);
        check("car5_cleared", int'(floor_btn), 'h00);
        check("here_still_high", int'(req_here), 1);
        tick(1);
        check("here_fell", int'(req_here), 0);
        check("up2_kept", int'(up_call), 'h04);
        elevator_status = 4'b0000;

        // both hall calls at floor 3, served going down
        floor = 4'd0;
        up_btn[3] = 1'b1; down_btn[3] = 1'b1;
        tick(1);
        up_btn = '0; down_btn = '0;
        tick(3);
        check("hall3_up_set", int'(up_call), 'h0C);
        check("hall3_down_set", int'(down_call), 'h08);
        floor = 4'd3;
        elevator_status = 4'b0110;
        tick(1);
        check("down3_cleared", int'(down_call), 'h00);
        check("up3_kept", int'(up_call), 'h0C);
        elevator_status = 4'b0000;

        // forced-zero bits ignore presses
        up_btn[7] = 1'b1; down_btn[0] = 1'b1;
        tick(1);
        up_btn = '0; down_btn = '0;
        tick(5);
        check("top_up_ignored", int'(up_call), 'h0C);
        check("bottom_down_ignored", int'(down_call), 'h00);
        check("cnt_unchanged", int'(pending_cnt), 2);

        // clear up[3], then a set edge arriving while the door is still open
        elevator_status = 4'b1010;
        tick(1);
        check("up3_cleared", int'(up_call), 'h04);
        up_btn[3] = 1'b1;
        tick(1);
        up_btn[3] = 1'b0;
        tick(2);
        elevator_status = 4'b0000;
        tick(3);
        check("clear_wins", int'(up_call), 'h04);

        // four pending then async reset
        floor = 4'd0;
        car_btn = 8'hC1;
        tick(1);
        car_btn = '0;
        tick(5);
        check("four_pending", int'(pending_cnt), 4);
        #2;
        RST = 1'b0;
        #1;
        check_all_zero("async_reset");

        // car_btn[1] held across reset release
        car_btn[1] = 1'b1;
        tick(3);
        check("held_in_reset", int'(floor_btn), 'h00);
        RST = 1'b1;
        tick(2);
        check("held_early", int'(floor_btn), 'h00);
        tick(1);
        check("held_latched", int'(floor_btn), 'h02);
        tick(10);
        check("held_once", int'(floor_btn), 'h02);
        check("held_cnt", int'(pending_cnt), 1);
        car_btn[1] = 1'b0;
        tick(3);

        // re-press of a latched car button
        car_btn[4] = 1'b1;
        tick(1);
        car_btn[4] = 1'b0;
        tick(5);
        check("car4_first", int'(floor_btn), 'h12);
        car_btn[4] = 1'b1;
        tick(1);
        car_btn[4] = 1'b0;
        tick(5);
`ifdef CALL_CANCEL_EN
        check("car4_repress", int'(floor_btn), 'h02);
`else
        check("car4_repress", int'(floor_btn), 'h12);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
